// File: rtl/register_file_sb.sv
// Scoreboarded integer register file: N combinational read ports, one write-back
// port, and a per-register busy bit set by issue reservations and cleared by write-back.

module register_file_sb_rd #(
  parameter int RegWidth = 32,
  parameter int NRegs    = 32,
  parameter bit BypassEn = 1'b1,
  parameter int AW       = $clog2(NRegs)
) (
  input  logic [AW-1:0]                   addr,
  input  logic [NRegs-1:0][RegWidth-1:0]  regs,
  input  logic [NRegs-1:0]                busy,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  input  logic [RegWidth-1:0]             wr_data,
  output logic [RegWidth-1:0]             rs,
  output logic                            rs_busy
);
  logic hit;

  // x0 never forwards, so a write-back aimed at x0 cannot leak through.
  assign hit     = BypassEn && wr_en && (wr_addr == addr) && (addr != '0);
  assign rs      = hit ? wr_data : regs[addr];
  assign rs_busy = hit ? 1'b0 : busy[addr];
endmodule

module register_file_sb #(
  parameter int RegWidth   = 32,
  parameter int NRegs      = 32,
  parameter int NReadPorts = 2,
  parameter bit BypassEn   = 1'b1,
  localparam int AW        = $clog2(NRegs)
) (
  input  logic                           iClk,
  input  logic                           nRst,
  input  logic [NReadPorts*AW-1:0]       iAddr_Rs,
  output logic [NReadPorts*RegWidth-1:0] oRs,
  output logic [NReadPorts-1:0]          oRsBusy,
  input  logic                           iWriteEn,
  input  logic [AW-1:0]                  iAddr_Rd,
  input  logic [RegWidth-1:0]            iRd,
  input  logic                           iReserveEn,
  input  logic [AW-1:0]                  iAddr_Res,
  output logic                           oReserveAck,
  input  logic                           iFlush,
  output logic [NRegs-1:0]               oBusyVec
);
  logic [NRegs-1:0][RegWidth-1:0] regs;
  logic [NRegs-1:0]               busy, busy_nxt;
  logic                           wr_live;

  assign wr_live = iWriteEn && (iAddr_Rd != '0);

  // A write-back landing this cycle frees the register, so the new owner may claim it now.
  assign oReserveAck = iReserveEn && !iFlush && (iAddr_Res != '0) &&
                       (!busy[iAddr_Res] || (iWriteEn && (iAddr_Rd == iAddr_Res)));

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) regs <= '0;
    else if (wr_live) regs[iAddr_Rd] <= iRd;
  end

  // Reserve is applied after the write clear so a same-cycle re-reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (iFlush) begin
      busy_nxt = '0;
    end else begin
      if (wr_live)     busy_nxt[iAddr_Rd]  = 1'b0;
      if (oReserveAck) busy_nxt[iAddr_Res] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign oBusyVec = busy;

  for (genvar p = 0; p < NReadPorts; p++) begin : g_rd
    register_file_sb_rd #(
      .RegWidth(RegWidth), .NRegs(NRegs), .BypassEn(BypassEn), .AW(AW)
    ) u_rd (
      .addr    (iAddr_Rs[p*AW +: AW]),
      .regs    (regs),
      .busy    (busy),
      .wr_en   (iWriteEn),
      .wr_addr (iAddr_Rd),
      .wr_data (iRd),
      .rs      (oRs[p*RegWidth +: RegWidth]),
      .rs_busy (oRsBusy[p])
    );
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: bypassing and non-bypassing instances share stimulus
// and are checked against an array-based model of the register/busy state.

module tb_register_file_sb;
  localparam int W = 32, N = 32, P = 2, AW = 5;

  logic           iClk = 1'b0, nRst = 1'b0;
  logic [P*AW-1:0] iAddr_Rs;
  logic [P*W-1:0] rs_b, rs_n;
  logic [P-1:0]   rsb_b, rsb_n;
  logic           iWriteEn, iReserveEn, iFlush, ack_b, ack_n;
  logic [AW-1:0]  iAddr_Rd, iAddr_Res;
  logic [W-1:0]   iRd;
  logic [N-1:0]   bv_b, bv_n;

  int errors = 0, checks = 0;
  logic [W-1:0] mem [N];
  bit           bsy [N];
  logic [AW-1:0] ra [P];

  always #5 iClk = ~iClk;

  register_file_sb #(.RegWidth(W), .NRegs(N), .NReadPorts(P), .BypassEn(1'b1)) dut (
    .iClk(iClk), .nRst(nRst), .iAddr_Rs(iAddr_Rs), .oRs(rs_b), .oRsBusy(rsb_b),
    .iWriteEn(iWriteEn), .iAddr_Rd(iAddr_Rd), .iRd(iRd), .iReserveEn(iReserveEn),
    .iAddr_Res(iAddr_Res), .oReserveAck(ack_b), .iFlush(iFlush), .oBusyVec(bv_b));

  register_file_sb #(.RegWidth(W), .NRegs(N), .NReadPorts(P), .BypassEn(1'b0)) dut_nb (
    .iClk(iClk), .nRst(nRst), .iAddr_Rs(iAddr_Rs), .oRs(rs_n), .oRsBusy(rsb_n),
    .iWriteEn(iWriteEn), .iAddr_Rd(iAddr_Rd), .iRd(iRd), .iReserveEn(iReserveEn),
    .iAddr_Res(iAddr_Res), .oReserveAck(ack_n), .iFlush(iFlush), .oBusyVec(bv_n));

  always_comb for (int p = 0; p < P; p++) iAddr_Rs[p*AW +: AW] = ra[p];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rs(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && iWriteEn && iAddr_Rd == a) return iRd;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && iWriteEn && iAddr_Rd == a) return 1'b0;
    return bsy[a];
  endfunction

  function automatic logic exp_ack();
    return iReserveEn && !iFlush && iAddr_Res != 0 &&
           (!bsy[iAddr_Res] || (iWriteEn && iAddr_Rd == iAddr_Res));
  endfunction

  function automatic logic [N-1:0] exp_bv();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = bsy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mem[i] = '0; bsy[i] = 1'b0; end
  endtask

  task automatic model_step();
    logic a;
    a = exp_ack();
    if (iWriteEn && iAddr_Rd != 0) mem[iAddr_Rd] = iRd;
    if (iFlush) for (int i = 0; i < N; i++) bsy[i] = 1'b0;
    else begin
      if (iWriteEn && iAddr_Rd != 0) bsy[iAddr_Rd] = 1'b0;
      if (a) bsy[iAddr_Res] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < P; p++) begin
      chk($sformatf("rs%0d_byp a=%0d", p, ra[p]), rs_b[p*W +: W], exp_rs(ra[p], 1'b1));
      chk($sformatf("rs%0d_nobyp a=%0d", p, ra[p]), rs_n[p*W +: W], exp_rs(ra[p], 1'b0));
      chk($sformatf("rsbusy%0d_byp", p), {31'b0, rsb_b[p]}, {31'b0, exp_busy(ra[p], 1'b1)});
      chk($sformatf("rsbusy%0d_nobyp", p), {31'b0, rsb_n[p]}, {31'b0, exp_busy(ra[p], 1'b0)});
    end
    chk("ack_byp", {31'b0, ack_b}, {31'b0, exp_ack()});
    chk("ack_nobyp", {31'b0, ack_n}, {31'b0, exp_ack()});
    chk("busyvec_byp", bv_b, exp_bv());
    chk("busyvec_nobyp", bv_n, exp_bv());
  endtask

  task automatic idle();
    iWriteEn = 0; iAddr_Rd = '0; iRd = '0; iReserveEn = 0; iAddr_Res = '0; iFlush = 0;
    ra[0] = '0; ra[1] = '0;
  endtask

  task automatic cyc();
    #1 check_all();
    @(posedge iClk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    iWriteEn = 1; iAddr_Rd = a; iRd = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    iReserveEn = 1; iAddr_Res = a;
  endtask

  initial begin
    idle();
    model_reset();
    // reset state: every address on both ports reads 0, reservations still ack
    #2;
    for (int r = 0; r < N; r++) begin
      ra[0] = AW'(r); ra[1] = AW'(N-1-r); rsv(AW'(r));
      #1 check_all();
    end
    idle();
    @(negedge iClk) nRst = 1;
    @(posedge iClk); #1;

    // T1: basic write/read
    wr(5, 32'hDEADBEEF); cyc();
    idle(); ra[0] = 5; #1 chk("t1_x5", rs_b[W-1:0], 32'hDEADBEEF); cyc();

    // T2: x0 ignores writes and reservations; top register present
    wr(0, 32'h12345678); rsv(0); ra[0] = 0;
    #1 chk("t2_ack_x0", {31'b0, ack_b}, 32'h0); cyc();
    idle(); ra[0] = 0; #1 chk("t2_x0", rs_b[W-1:0], 32'h0);
    chk("t2_bv0", {31'b0, bv_b[0]}, 32'h0);
    wr(31, 32'hA5A5A5A5); cyc();
    idle(); ra[0] = 31; #1 chk("t2_x31", rs_b[W-1:0], 32'hA5A5A5A5); cyc();

    // T3: same-cycle bypass vs stored value
    wr(7, 32'h11); cyc();
    wr(7, 32'h55); ra[0] = 7; ra[1] = 7;
    #1 chk("t3_byp", rs_b[W-1:0], 32'h55);
    chk("t3_nobyp", rs_n[W-1:0], 32'h11);
    chk("t3_byp_p1", rs_b[2*W-1:W], 32'h55);
    cyc();
    idle(); ra[0] = 7; #1 chk("t3_nobyp_next", rs_n[W-1:0], 32'h55); cyc();

    // T4: reserve, re-reserve rejected, write-back clears
    rsv(3); #1 chk("t4_ack", {31'b0, ack_b}, 32'h1); cyc();
    idle(); #1 chk("t4_busy", {31'b0, bv_b[3]}, 32'h1);
    rsv(3); #1 chk("t4_reack", {31'b0, ack_b}, 32'h0); cyc();
    idle(); wr(3, 32'h9); cyc();
    idle(); ra[0] = 3; #1 chk("t4_clear", {31'b0, bv_b[3]}, 32'h0);
    chk("t4_data", rs_b[W-1:0], 32'h9); cyc();

    // T5: write + reserve same register while busy
    rsv(3); cyc();
    idle(); wr(3, 32'h42); rsv(3); #1 chk("t5_ack", {31'b0, ack_b}, 32'h1); cyc();
    idle(); ra[0] = 3; #1 chk("t5_data", rs_b[W-1:0], 32'h42);
    chk("t5_busy", {31'b0, bv_b[3]}, 32'h1); cyc();

    // T6: flush beats reservation, write still lands
    idle(); rsv(1); cyc(); rsv(2); cyc(); rsv(4); cyc();
    idle(); iFlush = 1; rsv(6); wr(1, 32'h7);
    #1 chk("t6_ack", {31'b0, ack_b}, 32'h0); cyc();
    idle(); ra[0] = 1; #1 chk("t6_bv", bv_b, 32'h0);
    chk("t6_x1", rs_b[W-1:0], 32'h7); cyc();

    // mid-operation async reset
    rsv(9); cyc(); idle(); wr(12, 32'hCAFE0001); cyc();
    idle(); ra[0] = 12; ra[1] = 9; #2 nRst = 0; model_reset();
    #1 chk("rst_x12", rs_b[W-1:0], 32'h0);
    chk("rst_bv", bv_b, 32'h0);
    check_all();
    @(negedge iClk) nRst = 1;
    @(posedge iClk); #1;

    // randomized traffic, biased toward a few registers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      idle();
      iWriteEn   = ($urandom_range(0, 1) == 1);
      iAddr_Rd   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      iRd        = $urandom;
      iReserveEn = ($urandom_range(0, 1) == 1);
      iAddr_Res  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      iFlush     = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < P; p++)
        ra[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      if ($urandom_range(0, 3) == 0) ra[0] = iAddr_Rd;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised, scoreboarded integer register file for the rv32 core, and the successor to the fixed 2-read/1-write file.
- Width, register count and read-port count are configurable.
- Register 0 is hardwired to zero.
- Same-cycle write-to-read bypass is optional.
- Each register has a busy (pending-write) bit so issue logic can detect RAW/WAW hazards.
- Sits between decode/issue (reads, reservations) and write-back (writes).

Parameters:
RegWidth, 32, data width of each register.
NRegs, 32, register count including x0; power of two, >= 2.
NReadPorts, 2, number of independent read ports, >= 1.
BypassEn, 1, 1 = a read of a register being written this cycle returns iRd; 0 = it returns the stored value.

Ports:
iClk  in  1  clock, rising edge.
nRst  in  1  asynchronous active-low reset.
iAddr_Rs  in  NReadPorts*AW  packed read addresses; port p = bits [p*AW +: AW]; AW = $clog2(NRegs).
oRs  out  NReadPorts*RegWidth  packed read data, same packing.
oRsBusy  out  NReadPorts  busy bit of each addressed register.
iWriteEn  in  1  write-back valid.
iAddr_Rd  in  AW  write-back destination.
iRd  in  RegWidth  write-back data.
iReserveEn  in  1  issue requests ownership of a destination.
iAddr_Res  in  AW  register to reserve.
oReserveAck  out  1  reservation accepted this cycle.
iFlush  in  1  clear all busy bits (pipeline flush).
oBusyVec  out  NRegs  all busy bits; bit 0 is always 0.

Behaviour:
- Reset (nRst low, asynchronous):
  - All registers go to 0 and all busy bits go to 0.
  - Combinational outputs follow from the reset state: oRs = 0 for any address, oRsBusy = 0, oBusyVec = 0.
  - oReserveAck = iReserveEn & (iAddr_Res != 0) (register not busy after reset).
- Storage: registers 1..NRegs-1 are all implemented and writable. x0 reads 0; writes and reservations to x0 are ignored.
- Write: if iWriteEn and iAddr_Rd != 0, the register takes iRd at the rising edge, and its busy bit clears at the same edge unless re-reserved (see priority).
- Read (combinational, zero latency): oRs[p] = stored value of iAddr_Rs[p].
  - If BypassEn=1, iWriteEn=1, iAddr_Rd == iAddr_Rs[p] and the address is not 0, then oRs[p] = iRd.
- oRsBusy[p] = busy[iAddr_Rs[p]].
  - If BypassEn=1 and a write to that register is present this cycle, oRsBusy[p] = 0.
  - With BypassEn=0, oRsBusy[p] reflects only the stored busy bit.
- Reservation: oReserveAck = iReserveEn & (iAddr_Res != 0) & (~busy[iAddr_Res] | (iWriteEn & iAddr_Rd == iAddr_Res)).
  - On ack, the busy bit sets at the next edge.
  - A rejected request changes nothing; the requester stalls and retries.
- Next-state priority per busy bit, highest first:
  1. iFlush: all bits go to 0, reservations that cycle are ignored, and oReserveAck is forced to 0.
  2. Acked reserve: bit goes to 1.
  3. Write: bit goes to 0.
  4. Otherwise: hold.
- Write + acked reserve to the same register in one cycle: data updates to iRd and the busy bit stays 1 (new producer owns it).
- iFlush does not block a same-cycle write; the data is still written.
- Multiple read ports may address the same register; each returns identical data.
- Write to a non-busy register is legal (no error); the busy bit stays 0.
- Reset asserted mid-operation overrides all pending writes and reservations.

Test Plan:
1. Reset, then read x0..x31 on both ports -> all oRs = 0, oBusyVec = 0; write x5=0xDEADBEEF, next cycle read x5 -> 0xDEADBEEF.
2. Write x0=0x12345678, reserve x0 -> x0 reads 0, oReserveAck = 0, oBusyVec[0] = 0; write x31=0xA5A5A5A5 -> x31 reads back correctly (top register present).
3. BypassEn=1: same cycle write x7=0x55 and read x7 with stored 0x11 -> oRs = 0x55, oRsBusy = 0. BypassEn=0, same stimulus -> oRs = 0x11, then 0x55 next cycle.
4. Reserve x3 -> ack=1, next cycle oBusyVec[3] = 1. Reserve x3 again -> ack=0. Write x3=0x9 -> busy clears next cycle, data = 0x9.
5. x3 busy; same cycle write x3=0x42 plus reserve x3 -> ack=1, x3 = 0x42, oBusyVec[3] stays 1.
6. Reserve x1, x2, x4, then assert iFlush with reserve x6 and write x1=0x7 -> oReserveAck = 0, oBusyVec all 0 next cycle, x1 = 0x7. Assert nRst low mid-sequence -> all state 0 immediately.
